seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 134 +++++++++++++
 tb/tb_seq_divider.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, signed/unsigned,
// with divide-by-zero shortcut and registered, held results.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dz_pend_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH:0]   r_sh_c;
    logic [WIDTH:0]   diff_c;
    logic             qbit_c;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] a_d;
    logic             accept_c;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (-x) : x;
    endfunction

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        r_sh_c = {r_q, a_q[WIDTH-1]};
        diff_c = r_sh_c - {1'b0, b_q};
        qbit_c = ~diff_c[WIDTH];
        r_d    = qbit_c ? diff_c[WIDTH-1:0] : r_sh_c[WIDTH-1:0];
        a_d    = {a_q[WIDTH-2:0], qbit_c};
    end

    // A pending divide-by-zero holds off new starts for its single IDLE cycle.
    assign accept_c = start && (((state_q == IDLE) && !dz_pend_q) || (state_q == DONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE) state_q <= IDLE;
                    if (dz_pend_q) begin
                        dz_pend_q <= 1'b0;
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        quo_q     <= '1;
                        rem_q     <= a_q;
                        dbz_q     <= 1'b1;
                    end else if (accept_c) begin
                        dbz_q     <= 1'b0;
                        neg_quo_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_q <= is_signed & dividend[WIDTH-1];
                        b_q       <= mag(divisor, is_signed);
                        r_q       <= '0;
                        cnt_q     <= CW'(WIDTH);
                        if (divisor == '0) begin
                            a_q       <= dividend;
                            dz_pend_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            a_q     <= mag(dividend, is_signed);
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q   <= r_d;
                    a_q   <= a_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= FIX;
                end
                FIX: begin
                    quo_q   <= neg_quo_q ? (-a_q) : a_q;
                    rem_q   <= neg_rem_q ? (-r_q) : r_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32) with hand-computed expectations.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;
    int lat;
    int busy_cnt;
    int done_seen;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive operands on the falling edge; E0 is the following rising edge.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        is_signed = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
    endtask

    // Count edges until done; optionally pulse a new start after edge inj.
    task automatic wait_done(input int inj);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
            if (busy && done) busy_cnt += 1000;
            if (lat == inj) begin
                start = 1'b1; dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz);
        launch(s, a, b);
        wait_done(-1);
        chk({tag, "_lat"},  64'(lat),      edz ? 64'd1 : 64'd33);
        chk({tag, "_busy"}, 64'(busy_cnt), edz ? 64'd0 : 64'd33);
        chk({tag, "_q"},    64'(quotient), 64'(eq));
        chk({tag, "_r"},    64'(remainder), 64'(er));
        chk({tag, "_dz"},   64'(div_by_zero), 64'(edz));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q",    64'(quotient), 64'd0);
        chk("rst_r",    64'(remainder), 64'd0);
        chk("rst_dz",   64'(div_by_zero), 64'd0);
        @(negedge clk); reset = 1'b1;

        run("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'd0);
        chk("hold_q", 64'(quotient), 64'd14);

        run("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run("s_m6_3", 1'b1, 32'hFFFF_FFFA, 32'd3, 32'hFFFF_FFFE, 32'd0, 1'b0);
        run("u7_9",   1'b0, 32'd7, 32'd9, 32'd0, 32'd7, 1'b0);
        run("u5_0",   1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run("s5_0",   1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run("clr_dz", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run("s_ovf",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run("u_max1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);

        // New start mid-CALC must be ignored.
        launch(1'b0, 32'd100, 32'd7);
        wait_done(5);
        chk("midst_lat", 64'(lat), 64'd33);
        chk("midst_q",   64'(quotient), 64'd14);
        chk("midst_r",   64'(remainder), 64'd2);

        // Start during the done cycle is accepted.
        launch(1'b0, 32'd100, 32'd7);
        wait_done(-1);
        start = 1'b1; dividend = 32'd200; divisor = 32'd9; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        chk("b2b_done_low", 64'(done), 64'd0);
        chk("b2b_busy",     64'(busy), 64'd1);
        wait_done(-1);
        chk("b2b_lat", 64'(lat), 64'd33);
        chk("b2b_q",   64'(quotient), 64'd22);
        chk("b2b_r",   64'(remainder), 64'd2);

        // Asynchronous reset in the middle of CALC.
        launch(1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_q",    64'(quotient), 64'd0);
        chk("arst_r",    64'(remainder), 64'd0);
        chk("arst_dz",   64'(div_by_zero), 64'd0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        @(negedge clk); reset = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("arst_nodone", 64'(done_seen), 64'd0);
        run("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
